// File: rtl/ntt_addr_pkg.sv
// Shared types and the index-reversal helper used by the NTT address generators.
// rev_idx works on a fixed wide index so any generator width can reuse it.
package ntt_addr_pkg;

   localparam int IDX_MAX_W = 32;

   typedef enum logic [1:0] {
      REV_NAT  = 2'd0,
      REV_BIT  = 2'd1,
      REV_DIG  = 2'd2,
      REV_RSVD = 2'd3
   } rev_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } gen_state_e;

   // Reverses the low W = l*radix_k bits of idx; the bits above W are returned as 0.
   // Each output bit o picks its source bit: W-1-o for bit reversal, or the same bit
   // position inside the mirrored digit for digit reversal.
   function automatic logic [IDX_MAX_W-1:0] rev_idx(
      input logic [IDX_MAX_W-1:0] idx,
      input int unsigned          l,
      input rev_mode_e            mode,
      input int unsigned          radix_k
   );
      logic [IDX_MAX_W-1:0] res;
      int unsigned          w;
      int unsigned          src;
      res = '0;
      w   = l * radix_k;
      for (int unsigned o = 0; o < IDX_MAX_W; o++) begin
         src = o;
         if (mode == REV_BIT) begin
            src = w - 1 - o;
         end else if (mode == REV_DIG) begin
            src = (l - 1 - o / radix_k) * radix_k + o % radix_k;
         end
         if ((o < w) && (((idx >> src) & IDX_MAX_W'(1)) != '0)) begin
            res = res | (IDX_MAX_W'(1) << o);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/digit_rev_lane.sv
// One output lane: combinational mapping of a natural index to its natural,
// bit-reversed or digit-reversed counterpart for the given stage count and mode.
module digit_rev_lane
   import ntt_addr_pkg::*;
#(
   parameter int D_WIDTH = 12,
   parameter int RADIX_K = 2
) (
   input  logic [D_WIDTH-1:0] idx,
   input  logic [D_WIDTH-1:0] l,
   input  logic [1:0]         mode,
   output logic [D_WIDTH-1:0] idx_rev
);

   assign idx_rev = D_WIDTH'(rev_idx(IDX_MAX_W'(idx), IDX_MAX_W'(l), rev_mode_e'(mode), RADIX_K));

endmodule

// File: rtl/digit_rev_addr_gen.sv
// Streaming NTT/INTT index generator: emits all 2^(RADIX_K*l) indices of one stage,
// LANES per beat, in natural, bit-reversed or digit-reversed order with valid/ready.
module digit_rev_addr_gen
   import ntt_addr_pkg::*;
#(
   parameter int D_WIDTH = 12,
   parameter int RADIX_K = 2,
   parameter int L_MAX   = 6,
   parameter int LANES   = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [D_WIDTH-1:0]         cfg_l,
   input  logic [1:0]                 cfg_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*D_WIDTH-1:0]   out_idx,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done,
   output logic                       cfg_err
);

   localparam int LANES_LOG = $clog2(LANES);

   gen_state_e               state;
   gen_state_e               state_d;
   logic [D_WIDTH-1:0]       cnt;
   logic [D_WIDTH-1:0]       l_q;
   rev_mode_e                mode_q;
   logic [D_WIDTH-1:0]       l_sel;
   logic [1:0]               mode_sel;
   logic [D_WIDTH-1:0]       last_beat;
   logic [LANES*D_WIDTH-1:0] lane_rev;
   logic                     cfg_bad;
   logic                     can_load;
   logic                     is_last;
   logic                     load_beat;
   logic                     latch_cfg;
   logic                     clear_valid;
   logic                     err_d;
   logic                     done_d;

   // The first beat is built from the live cfg inputs in IDLE so it can appear one cycle after start.
   assign l_sel    = (state == IDLE) ? cfg_l : l_q;
   assign mode_sel = (state == IDLE) ? cfg_mode : mode_q;

   assign cfg_bad   = (cfg_l > D_WIDTH'(L_MAX)) || (cfg_mode == 2'd3);
   assign last_beat = D_WIDTH'((1 << (RADIX_K * int'(l_sel) - LANES_LOG)) - 1);
   assign is_last   = (cnt == last_beat);
   assign can_load  = !out_valid || out_ready;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [D_WIDTH-1:0] lane_idx;
      assign lane_idx = D_WIDTH'(int'(cnt) * LANES + j);

      digit_rev_lane #(
         .D_WIDTH (D_WIDTH),
         .RADIX_K (RADIX_K)
      ) u_lane (
         .idx     (lane_idx),
         .l       (l_sel),
         .mode    (mode_sel),
         .idx_rev (lane_rev[j*D_WIDTH +: D_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d     = state;
      load_beat   = 1'b0;
      latch_cfg   = 1'b0;
      clear_valid = 1'b0;
      err_d       = 1'b0;
      done_d      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else if (cfg_l == '0) begin
                  done_d = 1'b1;
               end else begin
                  latch_cfg = 1'b1;
                  load_beat = 1'b1;
                  state_d   = is_last ? FIN : RUN;
               end
            end
         end
         RUN: begin
            if (can_load) begin
               load_beat = 1'b1;
               if (is_last) begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            // Only the final beat is outstanding here; retire it and finish.
            if (out_valid && out_ready) begin
               clear_valid = 1'b1;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         l_q       <= '0;
         mode_q    <= REV_NAT;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update based on pre-edge values.
         cfg_err <= err_d;
         done    <= done_d;

         if (latch_cfg) begin
            l_q    <= cfg_l;
            mode_q <= rev_mode_e'(cfg_mode);
            busy   <= 1'b1;
         end else if (done_d) begin
            busy <= 1'b0;
         end

         if (load_beat) begin
            out_valid <= 1'b1;
            out_idx   <= lane_rev;
            out_last  <= is_last;
            cnt       <= is_last ? '0 : cnt + D_WIDTH'(1);
         end else if (clear_valid) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_digit_rev_addr_gen.sv
// Self-checking bench for digit_rev_addr_gen: behavioural index model, per-cycle
// beat/hold comparison, directed corner cases and randomized stages.
module tb_digit_rev_addr_gen;

   localparam int DW    = 12;
   localparam int RK    = 2;
   localparam int LM    = 6;
   localparam int LANES = 2;

   typedef struct packed {
      logic [LANES*DW-1:0] idx;
      logic                last;
   } beat_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [DW-1:0]       cfg_l = '0;
   logic [1:0]          cfg_mode = '0;
   logic                out_ready = 1'b0;
   logic                out_valid;
   logic [LANES*DW-1:0] out_idx;
   logic                out_last;
   logic                busy;
   logic                done;
   logic                cfg_err;

   int    checks = 0;
   int    errors = 0;
   int    ready_mode = 0;
   beat_t exp_q[$];
   beat_t got_q[$];
   logic  hold_pending = 1'b0;
   beat_t held;

   digit_rev_addr_gen #(
      .D_WIDTH (DW),
      .RADIX_K (RK),
      .L_MAX   (LM),
      .LANES   (LANES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_l     (cfg_l),
      .cfg_mode  (cfg_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference reversal: bits (or 2-bit digits) are read LSB-first and shifted in from the
   // right, so the first one read ends up most significant.
   function automatic int model_rev(input int x, input int l, input int mode);
      int r = 0;
      if (mode == 1) begin
         for (int i = 0; i < RK * l; i++) r = (r << 1) | ((x >> i) & 1);
      end else if (mode == 2) begin
         for (int d = 0; d < l; d++) r = (r << RK) | ((x >> (RK * d)) & ((1 << RK) - 1));
      end else begin
         r = x;
      end
      return r;
   endfunction

   task automatic push_stage(input int l, input int mode);
      int    nb;
      beat_t e;
      nb = (1 << (RK * l)) / LANES;
      for (int b = 0; b < nb; b++) begin
         e.idx = '0;
         for (int j = 0; j < LANES; j++) begin
            e.idx[j*DW +: DW] = DW'(model_rev(b * LANES + j, l, mode));
         end
         e.last = (b == nb - 1);
         exp_q.push_back(e);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Mid-cycle compare against the model queue, plus the stall-stability rule.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("hold_valid", out_valid, 1);
            check("hold_idx", out_idx, held.idx);
            check("hold_last", out_last, held.last);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", out_valid, 0);
            end else begin
               check("beat_idx", out_idx, exp_q[0].idx);
               check("beat_last", out_last, exp_q[0].last);
            end
            if (out_ready) begin
               got_q.push_back({out_idx, out_last});
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               hold_pending = 1'b0;
            end else begin
               hold_pending = 1'b1;
               held.idx     = out_idx;
               held.last    = out_last;
            end
         end else begin
            hold_pending = 1'b0;
         end
      end
   end

   task automatic wait_done(input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 64'(seen), 1);
      check("busy_at_done", busy, 0);
      check("queue_drained", 64'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   task automatic run_stage(input int l, input int mode, input int rmode, input bit b2b);
      bit bad;
      bad        = (l > LM) || (mode == 3);
      ready_mode = rmode;
      got_q.delete();
      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      start    = 1'b1;
      cfg_l    = DW'(l);
      cfg_mode = 2'(mode);
      if (!bad && l > 0) push_stage(l, mode);
      @(posedge clk);
      #1;
      start    = 1'b0;
      cfg_l    = DW'($urandom);
      cfg_mode = 2'($urandom);
      @(negedge clk);
      if (bad) begin
         check("err_pulse", cfg_err, 1);
         check("err_busy", busy, 0);
         check("err_valid", out_valid, 0);
         @(negedge clk);
         check("err_one_cycle", cfg_err, 0);
         check("err_no_beat", out_valid, 0);
      end else if (l == 0) begin
         check("l0_done", done, 1);
         check("l0_valid", out_valid, 0);
         check("l0_busy", busy, 0);
      end else begin
         check("start_busy", busy, 1);
         check("start_latency", out_valid, 1);
         check("start_no_err", cfg_err, 0);
         wait_done(8 * (1 << (RK * l)) + 50);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_idx", out_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      #1;
      rst_n = 1'b1;

      // l=1 bit-reverse: {0,2} then {1,3} with last on the second beat
      run_stage(1, 1, 0, 0);
      check("t1_beats", 64'(got_q.size()), 2);
      if (got_q.size() == 2) begin
         check("t1_beat0", got_q[0], {12'd2, 12'd0, 1'b0});
         check("t1_beat1", got_q[1], {12'd3, 12'd1, 1'b1});
      end

      // l=2 digit-reverse and bit-reverse literals
      run_stage(2, 2, 0, 0);
      check("t2_beats", 64'(got_q.size()), 8);
      if (got_q.size() == 8) begin
         check("t2_dig_beat0", got_q[0], {12'd4, 12'd0, 1'b0});
         check("t2_dig_beat3", got_q[3], {12'd13, 12'd9, 1'b0});
         check("t2_dig_last", 64'(got_q[7].last), 1);
      end
      run_stage(2, 1, 0, 0);
      if (got_q.size() == 8) check("t2_bit_beat3", got_q[3], {12'd14, 12'd6, 1'b0});
      else check("t2_bit_beats", 64'(got_q.size()), 8);

      // natural order under alternating backpressure
      run_stage(2, 0, 1, 0);
      check("stall_beats", 64'(got_q.size()), 8);

      // rejected and empty configurations
      run_stage(7, 0, 0, 0);
      run_stage(1, 3, 0, 0);
      run_stage(0, 0, 0, 0);

      // start while busy is ignored
      ready_mode = 1;
      got_q.delete();
      @(posedge clk);
      #1;
      start    = 1'b1;
      cfg_l    = DW'(2);
      cfg_mode = 2'd0;
      push_stage(2, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      start    = 1'b1;
      cfg_l    = DW'(1);
      cfg_mode = 2'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_start_no_err", cfg_err, 0);
      wait_done(200);
      check("busy_start_beats", 64'(got_q.size()), 8);
      if (got_q.size() == 8) check("busy_start_final", got_q[7], {12'd15, 12'd14, 1'b1});

      // start in the done cycle is accepted
      run_stage(1, 0, 0, 0);
      run_stage(1, 2, 0, 1);

      // largest stage
      run_stage(6, 2, 0, 0);
      check("lmax_beats", 64'(got_q.size()), 2048);

      // asynchronous reset mid-stage, then restart
      ready_mode = 0;
      got_q.delete();
      @(posedge clk);
      #1;
      start    = 1'b1;
      cfg_l    = DW'(2);
      cfg_mode = 2'd1;
      push_stage(2, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (got_q.size() >= 3) break;
      end
      check("rst_reached_beat3", 64'(got_q.size() >= 3), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_idx", out_idx, 0);
      check("arst_last", out_last, 0);
      check("arst_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("arst_no_done", done, 0);
      check("arst_no_beat", out_valid, 0);
      run_stage(1, 1, 0, 0);
      check("arst_restart_beats", 64'(got_q.size()), 2);
      if (got_q.size() == 2) begin
         check("arst_restart_beat0", got_q[0], {12'd2, 12'd0, 1'b0});
         check("arst_restart_beat1", got_q[1], {12'd3, 12'd1, 1'b1});
      end

      // randomized stages, including rejected and empty configurations
      for (int n = 0; n < 24; n++) begin
         int l;
         l = $urandom_range(0, 6);
         if (l == 6) l = 7;
         run_stage(l, $urandom_range(0, 3), $urandom_range(0, 2), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
